panel_frame_loader: RTL and testbench
=====================================

Name: panel_frame_loader

Overview:
- Upstream stage of the panel driver. Accepts a raster-order RGB565 pixel stream with a valid/ready handshake and start-of-frame marker.
- Writes each pixel into the two panel RAM banks: bank 1 holds the top half of the panel, bank 2 the bottom half.
- Double-buffers the frame: it writes one page while the driver scans the other, and swaps pages only on the driver's end-of-scan strobe, so no frame tears.

Parameters:
COL_BITS, 6, log2 of panel columns (64)
ROW_BITS, 6, log2 of total panel rows (64); each bank holds 2^(ROW_BITS-1) rows

Ports:
i_clk  in  1  core clock
i_reset  in  1  synchronous, active-high reset
i_pixel_data  in  16  RGB565 pixel: [15:11] R, [10:5] G, [4:0] B
i_pixel_valid  in  1  pixel present on i_pixel_data
i_pixel_sof  in  1  qualifies the current pixel as the frame's first (top-left)
o_pixel_ready  out  1  loader accepts the pixel this cycle
o_ram_wr_addr  out  COL_BITS+ROW_BITS-1 (11)  bank-local address = row_in_half*2^COL_BITS + col
o_ram_wr_data  out  16  pixel to write
o_ram_b1_we  out  1  write strobe, bank 1 (top half)
o_ram_b2_we  out  1  write strobe, bank 2 (bottom half)
o_wr_page  out  1  page being written (RAM page-select for write port)
o_disp_page  out  1  page the driver reads (RAM page-select for read port)
i_scan_done  in  1  one-cycle strobe from driver: full scan of all rows/bit-planes complete
o_frame_ready  out  1  complete frame loaded, awaiting swap
o_sync_err  out  1  sticky: SOF arrived mid-frame; cleared only by reset

Behaviour:
- Handshake: transfer occurs when i_pixel_valid && o_pixel_ready. Ready is combinational from state only, never from valid.
- Pixel counter pix_idx has COL_BITS+ROW_BITS bits (12). Its MSB selects the bank and its lower 11 bits form the address.
- States:
  - IDLE: ready=1.
    - Transfer with sof=1: write the pixel at index 0, set pix_idx=1, go to LOAD.
    - Transfer with sof=0: the pixel is discarded; no write.
  - LOAD: ready=1. Each transfer writes at pix_idx and increments pix_idx.
    - Transfer with sof=1: set o_sync_err=1, write the pixel at index 0, set pix_idx=1 (resync). The partial frame is abandoned.
    - Transfer of the last pixel (pix_idx = 4095, sof=0): go to WAIT_SWAP.
  - WAIT_SWAP: ready=0, o_frame_ready=1.
    - On i_scan_done: toggle o_disp_page, set o_wr_page to the new ~o_disp_page, go to IDLE.
    - i_scan_done is ignored in every other state.
- Write pipeline: transfer in cycle N drives addr/data/we in cycle N+1 for exactly one cycle.
  - Only one of b1_we/b2_we is high: b1 for pix_idx MSB=0, b2 for MSB=1.
  - addr and data hold their last value when we=0.
- o_wr_page is always ~o_disp_page.
- Simultaneous events:
  - i_scan_done in the same cycle as the last pixel's transfer is ignored; the swap waits for the next strobe.
  - The final write (cycle N+1) completes before any swap can occur.
- Reset (any state, mid-frame included):
  - state=IDLE, pix_idx=0.
  - o_disp_page=0, o_wr_page=1.
  - we=0, addr=0, data=0.
  - o_frame_ready=0, o_sync_err=0.
  - o_pixel_ready=0 during reset, 1 in the first cycle after.
  - A write staged in the pipeline at reset is dropped.

Test Plan:
- Reset, then one full frame with sof on the first pixel, data = index: 4096 writes. Check: pixel 0 -> b1 addr 0; pixel 2047 -> b1 addr 2047; pixel 2048 -> b2 addr 0; pixel 4095 -> b2 addr 2047. Each we is a single-cycle pulse one cycle after transfer. Ends in WAIT_SWAP with ready=0 and frame_ready=1.
- After a full frame, hold i_scan_done low for 100 cycles -> pages unchanged, no writes. Pulse i_scan_done -> next cycle disp_page=1, wr_page=0, ready=1, frame_ready=0.
- Stream 10 pixels without sof in IDLE -> no we pulses; ready stays 1. The next sof pixel writes b1 addr 0.
- Send sof, 300 pixels, then sof again -> o_sync_err=1 (sticky). The second sof pixel writes b1 addr 0, and the frame completes after 4096 pixels counted from the second sof.
- Last pixel accepted in the same cycle i_scan_done pulses -> no swap. The next i_scan_done swaps.
- Assert reset after 1000 pixels -> all outputs at reset values, disp_page=0, no pending write emitted. A new sof frame loads normally.

Source files
------------

// File: rtl/panel_frame_loader.sv
// Raster RGB565 pixel loader for a two-bank, double-buffered panel RAM.
// Splits each frame into top/bottom banks and swaps pages only on scan completion.
module panel_frame_loader #(
  parameter int COL_BITS = 6,
  parameter int ROW_BITS = 6
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [15:0]                  i_pixel_data,
  input  logic                         i_pixel_valid,
  input  logic                         i_pixel_sof,
  output logic                         o_pixel_ready,
  output logic [COL_BITS+ROW_BITS-2:0] o_ram_wr_addr,
  output logic [15:0]                  o_ram_wr_data,
  output logic                         o_ram_b1_we,
  output logic                         o_ram_b2_we,
  output logic                         o_wr_page,
  output logic                         o_disp_page,
  input  logic                         i_scan_done,
  output logic                         o_frame_ready,
  output logic                         o_sync_err
);
  localparam int IDX_W  = COL_BITS + ROW_BITS;
  localparam int ADDR_W = IDX_W - 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_SWAP} state_t;

  state_t           state;
  logic [IDX_W-1:0] pix_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             xfer;
  logic             wr_hit;

  // Ready depends only on state (and reset), never on valid.
  assign o_pixel_ready = !i_reset && (state != WAIT_SWAP);
  assign xfer          = i_pixel_valid && o_pixel_ready;
  assign wr_hit        = xfer && (i_pixel_sof || state == LOAD);
  assign wr_idx        = i_pixel_sof ? '0 : pix_idx;
  assign o_wr_page     = ~o_disp_page;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      pix_idx       <= '0;
      o_disp_page   <= 1'b0;
      o_ram_b1_we   <= 1'b0;
      o_ram_b2_we   <= 1'b0;
      o_ram_wr_addr <= '0;
      o_ram_wr_data <= '0;
      o_frame_ready <= 1'b0;
      o_sync_err    <= 1'b0;
    end else begin
      o_ram_b1_we <= 1'b0;
      o_ram_b2_we <= 1'b0;
      // Index MSB picks the half-panel bank; the rest is the bank-local address.
      if (wr_hit) begin
        o_ram_wr_addr <= wr_idx[ADDR_W-1:0];
        o_ram_wr_data <= i_pixel_data;
        o_ram_b1_we   <= !wr_idx[IDX_W-1];
        o_ram_b2_we   <= wr_idx[IDX_W-1];
        pix_idx       <= wr_idx + IDX_W'(1);
      end
      case (state)
        IDLE: if (wr_hit) state <= LOAD;
        LOAD: begin
          if (xfer) begin
            if (i_pixel_sof) begin
              o_sync_err <= 1'b1;
            end else if (&pix_idx) begin
              state         <= WAIT_SWAP;
              o_frame_ready <= 1'b1;
            end
          end
        end
        WAIT_SWAP: begin
          if (i_scan_done) begin
            o_disp_page   <= ~o_disp_page;
            o_frame_ready <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_panel_frame_loader.sv
// Randomized bench for panel_frame_loader against a frame-position reference model.
module tb_panel_frame_loader;
  localparam int COL_BITS = 6;
  localparam int ROW_BITS = 6;
  localparam int TOTAL    = 1 << (COL_BITS + ROW_BITS);
  localparam int HALF     = TOTAL / 2;
  localparam int ADDR_W   = COL_BITS + ROW_BITS - 1;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic [15:0]       i_pixel_data = '0;
  logic              i_pixel_valid = 1'b0;
  logic              i_pixel_sof = 1'b0;
  logic              o_pixel_ready;
  logic [ADDR_W-1:0] o_ram_wr_addr;
  logic [15:0]       o_ram_wr_data;
  logic              o_ram_b1_we, o_ram_b2_we;
  logic              o_wr_page, o_disp_page;
  logic              i_scan_done = 1'b0;
  logic              o_frame_ready, o_sync_err;

  panel_frame_loader #(.COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_pixel_data(i_pixel_data), .i_pixel_valid(i_pixel_valid), .i_pixel_sof(i_pixel_sof),
    .o_pixel_ready(o_pixel_ready),
    .o_ram_wr_addr(o_ram_wr_addr), .o_ram_wr_data(o_ram_wr_data),
    .o_ram_b1_we(o_ram_b1_we), .o_ram_b2_we(o_ram_b2_we),
    .o_wr_page(o_wr_page), .o_disp_page(o_disp_page),
    .i_scan_done(i_scan_done), .o_frame_ready(o_frame_ready), .o_sync_err(o_sync_err)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: where we are in the frame, expressed as a pixel count.
  bit        m_loading, m_wait, m_disp, m_err, m_we1, m_we2;
  int        m_cnt;
  int        m_addr, m_data;

  task automatic step(input bit v, input logic [15:0] d, input bit s, input bit sc, input bit r);
    bit xfer;
    int idx;
    i_reset = r; i_pixel_valid = v; i_pixel_data = d; i_pixel_sof = s; i_scan_done = sc;
    #1;
    chk("ready", o_pixel_ready, (!r && !m_wait));
    if (r) begin
      m_loading = 0; m_wait = 0; m_disp = 0; m_err = 0; m_cnt = 0;
      m_we1 = 0; m_we2 = 0; m_addr = 0; m_data = 0;
    end else begin
      m_we1 = 0; m_we2 = 0;
      xfer = v && !m_wait;
      if (m_wait && sc) begin
        m_disp = !m_disp;
        m_wait = 0;
      end else if (xfer && (s || m_loading)) begin
        if (s && m_loading) m_err = 1;
        idx    = s ? 0 : m_cnt;
        m_we1  = (idx < HALF);
        m_we2  = (idx >= HALF);
        m_addr = idx % HALF;
        m_data = d;
        m_cnt  = idx + 1;
        if (m_cnt == TOTAL) begin
          m_loading = 0; m_wait = 1; m_cnt = 0;
        end else m_loading = 1;
      end
    end
    @(posedge i_clk);
    @(negedge i_clk);
    chk("b1_we", o_ram_b1_we, m_we1);
    chk("b2_we", o_ram_b2_we, m_we2);
    chk("addr", o_ram_wr_addr, m_addr);
    chk("data", o_ram_wr_data, m_data);
    chk("disp_page", o_disp_page, m_disp);
    chk("wr_page", o_wr_page, !m_disp);
    chk("frame_ready", o_frame_ready, m_wait);
    chk("sync_err", o_sync_err, m_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 16'($urandom), 0, 0, 0);
  endtask

  // Random gaps carry junk sof/scan bits with valid low.
  task automatic pixel(input bit s, input bit sc);
    if ($urandom_range(0, 3) == 0)
      step(0, 16'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0 && !m_wait), 0);
    step(1, 16'($urandom), s, sc, 0);
  endtask

  task automatic frame(input int n);
    pixel(1, 0);
    for (int i = 1; i < n; i++) pixel(0, 0);
  endtask

  initial begin
    @(negedge i_clk);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("rst_addr", o_ram_wr_addr, 0);

    frame(TOTAL);
    chk("full_frame_ready", o_frame_ready, 1);
    chk("full_frame_rdy_low", o_pixel_ready, 0);
    idle(100);
    chk("no_swap_disp", o_disp_page, 0);
    step(0, 0, 0, 1, 0);
    chk("swap_disp", o_disp_page, 1);

    for (int i = 0; i < 10; i++) step(1, 16'($urandom), 0, 0, 0);
    frame(300);
    frame(TOTAL);
    chk("sync_err_sticky", o_sync_err, 1);
    step(0, 0, 0, 1, 0);

    pixel(1, 0);
    for (int i = 1; i < TOTAL - 1; i++) pixel(0, 0);
    step(1, 16'($urandom), 0, 1, 0);
    idle(3);
    chk("coincident_scan_ignored", o_frame_ready, 1);
    step(0, 0, 0, 1, 0);
    chk("late_swap_disp", o_disp_page, 1);

    frame(1000);
    step(0, 0, 0, 0, 1);
    step(1, 16'hbeef, 1, 0, 1);
    chk("post_rst_disp", o_disp_page, 0);
    frame(TOTAL);
    step(0, 0, 0, 1, 0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
